// File: rtl/pipeline_prog_pkg.sv
// Shared opcodes, FSM state encoding and response-word constants for the pipeline program loader.
// Optional feature macro used by the loader: PROG_LOADER_VERIFY_EN (write-verify of DMEM_WR).
package pipeline_prog_pkg;

   typedef logic [2:0] opcode_t;
   typedef logic [3:0] state_t;

   localparam opcode_t OP_NOP     = 3'd0;
   localparam opcode_t OP_IMEM_WR = 3'd1;
   localparam opcode_t OP_DMEM_WR = 3'd2;
   localparam opcode_t OP_DMEM_RD = 3'd3;
   localparam opcode_t OP_PC_RST  = 3'd4;
   localparam opcode_t OP_RUN     = 3'd5;
   localparam opcode_t OP_STEP    = 3'd6;

   localparam state_t ST_IDLE = 4'd0;
   localparam state_t ST_WR   = 4'd1;
   localparam state_t ST_RD   = 4'd2;
   localparam state_t ST_CAP  = 4'd3;
   localparam state_t ST_RSP  = 4'd4;
   localparam state_t ST_PCR1 = 4'd5;
   localparam state_t ST_PCR2 = 4'd6;
   localparam state_t ST_RUN  = 4'd7;
   localparam state_t ST_STEP = 4'd8;

   // Verify error word: MSB flag set, dmem address in the low bits, zeros between.
   localparam logic ERR_FLAG = 1'b1;

endpackage

// File: rtl/pipeline_prog_loader_run_counter.sv
// RUN cycle down-counter: load a value, decrement on request, flag when it reaches zero.
module prog_run_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/pipeline_prog_loader.sv
// Host command sequencer driving the pipeline core's programming ports, PC reset, run and step.
// Define PROG_LOADER_VERIFY_EN to read back and check every DMEM_WR, reporting the result as a response.
module pipeline_prog_loader
   import pipeline_prog_pkg::*;
#(
   parameter int IADDR_W  = 9,
   parameter int DADDR_W  = 8,
   parameter int DATA_W   = 64,
   parameter int RUNCNT_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [IADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0]  cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               busy,
   output logic               run,
   output logic               step,
   output logic               pc_reset_pulse,
   output logic               imem_prog_we,
   output logic [IADDR_W-1:0] imem_prog_addr,
   output logic [31:0]        imem_prog_wdata,
   output logic               dmem_prog_en,
   output logic               dmem_prog_we,
   output logic [DADDR_W-1:0] dmem_prog_addr,
   output logic [DATA_W-1:0]  dmem_prog_wdata,
   input  logic [DATA_W-1:0]  dmem_prog_rdata
);

   state_t               r_state;
   state_t               w_state_next;
   opcode_t              r_op;
   logic [IADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]    r_data;
   logic                 r_cmd_ready, r_busy, r_run, r_step, r_pcr;
   logic                 r_imem_we, r_dmem_en, r_dmem_we, r_rsp_valid;
   logic [IADDR_W-1:0]   r_imem_addr;
   logic [31:0]          r_imem_wdata;
   logic [DADDR_W-1:0]   r_dmem_addr;
   logic [DATA_W-1:0]    r_dmem_wdata;
   logic [DATA_W-1:0]    r_rsp_data;

   logic                 w_accept, w_cnt_zero, w_run_nonzero;
   logic                 w_wr_imem, w_wr_dmem, w_dmem_en;
   opcode_t              w_op;
   logic [IADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]    w_data;
   logic [DATA_W-1:0]    w_cap_data;

   assign w_accept      = cmd_valid & r_cmd_ready;
   assign w_op          = w_accept ? cmd_op   : r_op;
   assign w_addr        = w_accept ? cmd_addr : r_addr;
   assign w_data        = w_accept ? cmd_data : r_data;
   assign w_run_nonzero = |cmd_data[RUNCNT_W-1:0];

   // Counter holds remaining RUN cycles minus one, so zero marks the final run cycle.
   prog_run_counter #(.W(RUNCNT_W)) u_run_counter (
      .clk        (clk),
      .rst_n      (reset_n),
      .i_load     (w_accept && (cmd_op == OP_RUN)),
      .i_load_val (cmd_data[RUNCNT_W-1:0] - RUNCNT_W'(1)),
      .i_dec      ((r_state == ST_RUN) && !w_cnt_zero),
      .o_zero     (w_cnt_zero)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_IMEM_WR, OP_DMEM_WR: w_state_next = ST_WR;
                  OP_DMEM_RD:             w_state_next = ST_RD;
                  OP_PC_RST:              w_state_next = ST_PCR1;
                  OP_RUN:                 w_state_next = w_run_nonzero ? ST_RUN : ST_IDLE;
                  OP_STEP:                w_state_next = ST_STEP;
                  default:                w_state_next = ST_IDLE;
               endcase
            end
         end
`ifdef PROG_LOADER_VERIFY_EN
         ST_WR:   w_state_next = (r_op == OP_DMEM_WR) ? ST_RD : ST_IDLE;
`else
         ST_WR:   w_state_next = ST_IDLE;
`endif
         ST_RD:   w_state_next = ST_CAP;
         ST_CAP:  w_state_next = ST_RSP;
         ST_RSP:  w_state_next = rsp_ready ? ST_IDLE : ST_RSP;
         ST_PCR1: w_state_next = ST_PCR2;
         ST_PCR2: w_state_next = ST_IDLE;
         ST_RUN:  w_state_next = w_cnt_zero ? ST_IDLE : ST_RUN;
         ST_STEP: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_wr_imem = (w_state_next == ST_WR) && (w_op == OP_IMEM_WR);
   assign w_wr_dmem = (w_state_next == ST_WR) && (w_op == OP_DMEM_WR);
   assign w_dmem_en = w_wr_dmem || (w_state_next == ST_RD);

`ifdef PROG_LOADER_VERIFY_EN
   logic [DATA_W-1:0] w_err_word;

   always_comb begin
      w_err_word                = '0;
      w_err_word[DATA_W-1]      = ERR_FLAG;
      w_err_word[DADDR_W-1:0]   = r_addr[DADDR_W-1:0];
   end

   // A read reached via DMEM_WR is a verify readback; plain DMEM_RD returns the data itself.
   assign w_cap_data = (r_op != OP_DMEM_WR)        ? dmem_prog_rdata :
                       (dmem_prog_rdata == r_data) ? '0              : w_err_word;
`else
   assign w_cap_data = dmem_prog_rdata;
`endif

   // Every output is a flop computed from the next state, so each strobe lines up with its state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_op         <= OP_NOP;
         r_addr       <= '0;
         r_data       <= '0;
         r_cmd_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_run        <= 1'b0;
         r_step       <= 1'b0;
         r_pcr        <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_dmem_en    <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_op         <= w_op;
         r_addr       <= w_addr;
         r_data       <= w_data;
         r_cmd_ready  <= (w_state_next == ST_IDLE);
         r_busy       <= (w_state_next != ST_IDLE);
         r_run        <= (w_state_next == ST_RUN);
         r_step       <= (w_state_next == ST_STEP);
         r_pcr        <= (w_state_next == ST_PCR1);
         r_imem_we    <= w_wr_imem;
         r_imem_addr  <= w_wr_imem ? w_addr : '0;
         r_imem_wdata <= w_wr_imem ? w_data[31:0] : '0;
         r_dmem_en    <= w_dmem_en;
         r_dmem_we    <= w_wr_dmem;
         r_dmem_addr  <= w_dmem_en ? w_addr[DADDR_W-1:0] : '0;
         r_dmem_wdata <= w_wr_dmem ? w_data : '0;
         r_rsp_valid  <= (w_state_next == ST_RSP);
         if (r_state == ST_CAP) begin
            r_rsp_data <= w_cap_data;
         end
      end
   end

   assign cmd_ready       = r_cmd_ready;
   assign busy            = r_busy;
   assign run             = r_run;
   assign step            = r_step;
   assign pc_reset_pulse  = r_pcr;
   assign imem_prog_we    = r_imem_we;
   assign imem_prog_addr  = r_imem_addr;
   assign imem_prog_wdata = r_imem_wdata;
   assign dmem_prog_en    = r_dmem_en;
   assign dmem_prog_we    = r_dmem_we;
   assign dmem_prog_addr  = r_dmem_addr;
   assign dmem_prog_wdata = r_dmem_wdata;
   assign rsp_valid       = r_rsp_valid;
   assign rsp_data        = r_rsp_data;

endmodule

// File: tb/tb_pipeline_prog_loader.sv
// Directed self-checking bench for pipeline_prog_loader with a dmem model and a stand-in core.
// Define PROG_LOADER_VERIFY_EN for the bench and the design together to exercise write-verify.
module tb_pipeline_prog_loader;
   import pipeline_prog_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [8:0]  cmd_addr;
   logic [63:0] cmd_data;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic        busy, run, step, pc_reset_pulse;
   logic        imem_prog_we;
   logic [8:0]  imem_prog_addr;
   logic [31:0] imem_prog_wdata;
   logic        dmem_prog_en, dmem_prog_we;
   logic [7:0]  dmem_prog_addr;
   logic [63:0] dmem_prog_wdata;
   logic [63:0] dmem_prog_rdata = 64'h0;

   pipeline_prog_loader dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .run(run), .step(step), .pc_reset_pulse(pc_reset_pulse),
      .imem_prog_we(imem_prog_we), .imem_prog_addr(imem_prog_addr),
      .imem_prog_wdata(imem_prog_wdata),
      .dmem_prog_en(dmem_prog_en), .dmem_prog_we(dmem_prog_we),
      .dmem_prog_addr(dmem_prog_addr), .dmem_prog_wdata(dmem_prog_wdata),
      .dmem_prog_rdata(dmem_prog_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // dmem model with registered read; the stand-in core executes the store at imem[8] (dmem[4] <= dmem[0]).
   logic [63:0] dmem [256];
   logic        corrupt = 1'b0;
   int          core_pc = 0;

   always @(posedge clk) begin
      if (dmem_prog_en) begin
         if (dmem_prog_we) dmem[dmem_prog_addr] <= dmem_prog_wdata;
         else              dmem_prog_rdata <= dmem[dmem_prog_addr] ^ (corrupt ? 64'h1 : 64'h0);
      end
      if (pc_reset_pulse) begin
         core_pc <= 0;
      end else if (run || step) begin
         if (core_pc == 8) dmem[4] <= dmem[0];
         core_pc <= core_pc + 1;
      end
   end

   int          run_cycles = 0, run_rises = 0, step_cycles = 0, step_rises = 0;
   int          pcr_cycles = 0, imem_cycles = 0, overlap = 0;
   logic        prev_run = 1'b0, prev_step = 1'b0;
   logic [31:0] imem_mdl [512];

   always @(negedge clk) begin
      if (run)                 run_cycles  <= run_cycles + 1;
      if (run && !prev_run)    run_rises   <= run_rises + 1;
      if (step)                step_cycles <= step_cycles + 1;
      if (step && !prev_step)  step_rises  <= step_rises + 1;
      if (pc_reset_pulse)      pcr_cycles  <= pcr_cycles + 1;
      if (imem_prog_we) begin
         imem_cycles <= imem_cycles + 1;
         imem_mdl[imem_prog_addr] <= imem_prog_wdata;
      end
      if ((run || step) && (imem_prog_we || dmem_prog_en || pc_reset_pulse)) overlap <= overlap + 1;
      prev_run  <= run;
      prev_step <= step;
   end

   time accept_time = 0;

   task automatic send_cmd(input logic [2:0] op, input logic [8:0] addr, input logic [63:0] data);
      int waited = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check_value("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      accept_time = $time;
      #1 cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = '0; cmd_data = '0;
      $display("cmd op=%0d addr=0x%0h data=0x%0h accepted at %0t", op, addr, data, accept_time);
   endtask

   task automatic get_rsp(input int hold, input string tag, input logic [63:0] exp);
      int waited = 0;
      @(negedge clk);
      while (!rsp_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!rsp_valid) begin
         check_value({tag, "_valid_timeout"}, {63'd0, rsp_valid}, 64'd1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_value({tag, "_hold_data"}, rsp_data, exp);
         check_value({tag, "_hold_ready"}, {63'd0, cmd_ready}, 64'd0);
      end
      check_value(tag, rsp_data, exp);
      $display("rsp %s data=0x%0h", tag, rsp_data);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int waited = 0;
      @(negedge clk);
      while ((busy || !cmd_ready) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (busy) check_value("idle_timeout", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   logic [31:0] prog [9];
   int          base_a, base_b, base_c, base_d;
   time         t0;

   initial begin
      prog[0] = 32'h0000_3083;
      prog[1] = 32'h0040_3103;
      for (int i = 2; i < 8; i++) prog[i] = 32'h0000_0013;
      prog[8] = 32'h0010_3223;

      reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_value("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check_value("rst_busy", {63'd0, busy}, 64'd0);
      check_value("rst_strobes", {58'd0, run, step, pc_reset_pulse, imem_prog_we, dmem_prog_en, rsp_valid}, 64'd0);
      check_value("rst_rsp_data", rsp_data, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_value("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

      // Reset asserted mid-RUN drops everything without waiting for a clock edge.
      send_cmd(OP_RUN, 9'd0, 64'd50);
      repeat (10) @(negedge clk);
      check_value("run50_active", {63'd0, run}, 64'd1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check_value("async_rst_run", {63'd0, run}, 64'd0);
      check_value("async_rst_busy", {63'd0, busy}, 64'd0);
      check_value("async_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      repeat (3) @(negedge clk);
      check_value("held_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_value("release_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      check_value("release_run", {63'd0, run}, 64'd0);

      // dmem writes then reads
`ifdef PROG_LOADER_VERIFY_EN
      send_cmd(OP_DMEM_WR, 9'd0, 64'd4);
      get_rsp(0, "vfy_wr0", 64'd0);
      send_cmd(OP_DMEM_WR, 9'd4, 64'd100);
      get_rsp(0, "vfy_wr4", 64'd0);
`else
      send_cmd(OP_DMEM_WR, 9'd0, 64'd4);
      t0 = accept_time;
      send_cmd(OP_DMEM_WR, 9'd4, 64'd100);
      check_value("wr_throughput_ns", 64'(accept_time - t0), 64'd20);
      wait_idle();
      check_value("no_wr_rsp", {63'd0, rsp_valid}, 64'd0);
`endif
      send_cmd(OP_DMEM_RD, 9'd0, 64'd0);
      get_rsp(0, "rd0", 64'd4);
      send_cmd(OP_DMEM_RD, 9'd4, 64'd0);
      get_rsp(5, "rd4", 64'd100);

      // imem program load; upper data bits must not leak into the 32-bit port
      base_a = imem_cycles;
      for (int i = 0; i < 9; i++) send_cmd(OP_IMEM_WR, 9'(i), {32'hFFFF_FFFF, prog[i]});
      wait_idle();
      check_value("imem_pulse_cycles", 64'(imem_cycles - base_a), 64'd9);
      for (int i = 0; i < 9; i++) check_value($sformatf("imem_word%0d", i), {32'd0, imem_mdl[i]}, {32'd0, prog[i]});

      // PC reset then RUN 20; the stand-in core copies dmem[0] into dmem[4]
      base_a = pcr_cycles; base_b = run_cycles; base_c = run_rises;
      send_cmd(OP_PC_RST, 9'd0, 64'd0);
      send_cmd(OP_RUN, 9'd0, 64'd20);
      wait_idle();
      check_value("pcr_cycles", 64'(pcr_cycles - base_a), 64'd1);
      check_value("run20_cycles", 64'(run_cycles - base_b), 64'd20);
      check_value("run20_rises", 64'(run_rises - base_c), 64'd1);
      send_cmd(OP_DMEM_RD, 9'd4, 64'd0);
      get_rsp(0, "rd4_after_run", 64'd4);

      // three steps, RUN 0, op 7 and NOP
      base_a = step_cycles; base_b = step_rises;
      for (int i = 0; i < 3; i++) send_cmd(OP_STEP, 9'd0, 64'd0);
      wait_idle();
      check_value("step_rises", 64'(step_rises - base_a + step_rises - base_b - step_rises + base_a), 64'd3);
      check_value("step_cycles", 64'(step_cycles - base_a), 64'd3);
      base_a = run_cycles;
      send_cmd(OP_RUN, 9'd0, 64'd0);
      wait_idle();
      check_value("run0_cycles", 64'(run_cycles - base_a), 64'd0);
      base_a = run_cycles; base_b = step_cycles; base_c = pcr_cycles; base_d = imem_cycles;
      send_cmd(3'd7, 9'd0, 64'h55);
      send_cmd(OP_NOP, 9'd0, 64'h66);
      wait_idle();
      check_value("op7_side_effects", 64'((run_cycles - base_a) + (step_cycles - base_b) +
                  (pcr_cycles - base_c) + (imem_cycles - base_d)), 64'd0);
      check_value("op7_no_rsp", {63'd0, rsp_valid}, 64'd0);
      send_cmd(OP_DMEM_RD, 9'd0, 64'd0);
      get_rsp(0, "rd0_after_op7", 64'd4);

`ifdef PROG_LOADER_VERIFY_EN
      send_cmd(OP_DMEM_WR, 9'd8, 64'hDEAD);
      get_rsp(0, "vfy_match", 64'd0);
      corrupt = 1'b1;
      send_cmd(OP_DMEM_WR, 9'd8, 64'hBEEF);
      get_rsp(0, "vfy_mismatch", 64'h8000_0000_0000_0008);
      corrupt = 1'b0;
`endif

      check_value("run_step_vs_strobe_overlap", 64'(overlap), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
